uart_frame_scheduler: RTL and testbench



---
 rtl/acoustics_uart_pkg.sv | 36 +++
 rtl/uart_cmd_decoder.sv | 62 ++++++
 rtl/uart_frame_scheduler.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_frame_scheduler.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/acoustics_uart_pkg.sv
// Shared definitions for the ADC-to-UART frame scheduler: command codes,
// frame constants, the sequencer state encoding and the decoded command kinds.
package acoustics_uart_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF       = 8'hA5;
  localparam logic [7:0] CH_OPC_BASE         = 8'h40;

  localparam logic [7:0] CMD_ALL_CODE        = 8'h30;
  localparam logic [7:0] CMD_CH1_CODE        = 8'h31;
  localparam logic [7:0] CMD_CH2_CODE        = 8'h32;
  localparam logic [7:0] CMD_CH3_CODE        = 8'h33;
  localparam logic [7:0] CMD_CH4_CODE        = 8'h34;
  localparam logic [7:0] CMD_STREAM_ON_CODE  = 8'h53;
  localparam logic [7:0] CMD_STREAM_OFF_CODE = 8'h58;

  localparam logic [2:0] LAST_BYTE_IDX       = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_STROBE,
    ST_WAIT_BUSY,
    ST_WAIT_DONE,
    ST_NEXT_CH
  } sched_state_e;

  typedef enum logic [2:0] {
    CMD_NONE,
    CMD_SINGLE,
    CMD_ALL,
    CMD_STREAM_ON,
    CMD_STREAM_OFF,
    CMD_ERROR
  } cmd_kind_e;

endpackage

// File: rtl/uart_cmd_decoder.sv
// Host command decoder: detects the rising edge of rx_ready and classifies
// the received byte. Output is valid for exactly the edge cycle.
// Optional macro STREAM_MODE_EN enables the 'S'/'X' streaming commands;
// without it those bytes are reported as errors.
module uart_cmd_decoder
  import acoustics_uart_pkg::*;
(
  input  logic       clk,
  input  logic       reset_b,
  input  logic [7:0] rx_data,
  input  logic       rx_ready,
  output cmd_kind_e  cmd_kind,
  output logic [1:0] cmd_ch
);

  logic rx_ready_q;
  logic rx_rise;

  // Previous rx_ready level for edge detection
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      rx_ready_q <= 1'b0;
    end else begin
      rx_ready_q <= rx_ready;
    end
  end

  assign rx_rise = rx_ready & ~rx_ready_q;

  // Classify the byte only on the cycle the receive level rises
  always_comb begin
    cmd_kind = CMD_NONE;
    cmd_ch   = 2'd0;
    if (rx_rise) begin
      case (rx_data)
        CMD_ALL_CODE: cmd_kind = CMD_ALL;
        CMD_CH1_CODE: begin
          cmd_kind = CMD_SINGLE;
          cmd_ch   = 2'd0;
        end
        CMD_CH2_CODE: begin
          cmd_kind = CMD_SINGLE;
          cmd_ch   = 2'd1;
        end
        CMD_CH3_CODE: begin
          cmd_kind = CMD_SINGLE;
          cmd_ch   = 2'd2;
        end
        CMD_CH4_CODE: begin
          cmd_kind = CMD_SINGLE;
          cmd_ch   = 2'd3;
        end
`ifdef STREAM_MODE_EN
        CMD_STREAM_ON_CODE:  cmd_kind = CMD_STREAM_ON;
        CMD_STREAM_OFF_CODE: cmd_kind = CMD_STREAM_OFF;
`endif
        default: cmd_kind = CMD_ERROR;
      endcase
    end
  end

endmodule

// File: rtl/uart_frame_scheduler.sv
// Sequences UART TX on behalf of four ADC channels. A host command latches
// a coherent snapshot of all samples, then each requested channel is sent
// as a 5-byte frame (sync, opcode, sample high, sample low, XOR checksum)
// using a load / strobe / wait-busy / wait-done handshake per byte.
// Optional macro STREAM_MODE_EN adds continuous all-channel streaming
// controlled by 'S' (start) and 'X' (stop after the current frame).
module uart_frame_scheduler
  import acoustics_uart_pkg::*;
#(
  parameter int         SAMPLE_W   = 10,
  parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF,
  parameter int         TX_TIMEOUT = 4096
) (
  input  logic                  clk,
  input  logic                  reset_b,
  input  logic [7:0]            rx_data,
  input  logic                  rx_ready,
  input  logic [4*SAMPLE_W-1:0] sample_bus,
  input  logic                  tx_ready,
  output logic [7:0]            tx_data,
  output logic                  tx_en,
  output logic                  tx_write_en,
  output logic                  busy,
  output logic                  cmd_err,
  output logic                  cmd_drop,
  output logic                  timeout
);

  localparam int               CNT_W    = $clog2(TX_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_TIMEOUT - 1);

  cmd_kind_e             cmd_kind;
  logic [1:0]            cmd_ch;
  logic                  start_cmd;

  sched_state_e          state;
  logic [4*SAMPLE_W-1:0] snapshot;
  logic [1:0]            ch_idx;
  logic [2:0]            byte_idx;
  logic                  all_mode;
  logic [7:0]            csum;
  logic [CNT_W-1:0]      cnt;
  logic [SAMPLE_W-1:0]   cur_sample;

`ifdef STREAM_MODE_EN
  logic                  stream_on;
  logic                  stop_req;
  logic                  pass_wrap;
`endif

  uart_cmd_decoder u_dec (
    .clk      (clk),
    .reset_b  (reset_b),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .cmd_kind (cmd_kind),
    .cmd_ch   (cmd_ch)
  );

`ifdef STREAM_MODE_EN
  assign start_cmd = (cmd_kind == CMD_SINGLE) || (cmd_kind == CMD_ALL) ||
                     (cmd_kind == CMD_STREAM_ON);
`else
  assign start_cmd = (cmd_kind == CMD_SINGLE) || (cmd_kind == CMD_ALL);
`endif

  assign cur_sample = snapshot[int'(ch_idx)*SAMPLE_W +: SAMPLE_W];

  // Byte idx of the frame for channel ch; byte 4 is the running XOR
  function automatic logic [7:0] frame_byte(input logic [2:0]          idx,
                                            input logic [1:0]          ch,
                                            input logic [SAMPLE_W-1:0] smp,
                                            input logic [7:0]          acc);
    logic [15:0] wide;
    wide = 16'(smp);
    case (idx)
      3'd0:    return SYNC_BYTE;
      3'd1:    return CH_OPC_BASE + {6'd0, ch} + 8'd1;
      3'd2:    return wide[15:8];
      3'd3:    return wide[7:0];
      default: return acc;
    endcase
  endfunction

  // Sequencer: command acceptance, per-byte UART handshake and timeout abort
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state       <= ST_IDLE;
      snapshot    <= '0;
      ch_idx      <= 2'd0;
      byte_idx    <= 3'd0;
      all_mode    <= 1'b0;
      csum        <= 8'd0;
      cnt         <= '0;
      tx_data     <= 8'd0;
      tx_en       <= 1'b0;
      tx_write_en <= 1'b0;
      busy        <= 1'b0;
      cmd_err     <= 1'b0;
      cmd_drop    <= 1'b0;
      timeout     <= 1'b0;
`ifdef STREAM_MODE_EN
      stream_on   <= 1'b0;
      stop_req    <= 1'b0;
      pass_wrap   <= 1'b0;
`endif
    end else begin
      cmd_err  <= 1'b0;
      cmd_drop <= 1'b0;
      timeout  <= 1'b0;

      // Command side effects that apply regardless of sequencer position
      case (cmd_kind)
        CMD_ERROR: cmd_err <= 1'b1;
        CMD_SINGLE, CMD_ALL: begin
          if (state != ST_IDLE) cmd_drop <= 1'b1;
        end
`ifdef STREAM_MODE_EN
        CMD_STREAM_ON: begin
          if (state != ST_IDLE) begin
            stream_on <= 1'b1;
            stop_req  <= 1'b0;
          end
        end
        CMD_STREAM_OFF: begin
          if (state != ST_IDLE) stop_req <= 1'b1;
        end
`endif
        default: ;
      endcase

      case (state)
        ST_IDLE: begin
          if (start_cmd) begin
            snapshot <= sample_bus;
            ch_idx   <= (cmd_kind == CMD_SINGLE) ? cmd_ch : 2'd0;
            all_mode <= (cmd_kind != CMD_SINGLE);
            byte_idx <= 3'd0;
            csum     <= 8'd0;
            cnt      <= '0;
            tx_data  <= SYNC_BYTE;
            busy     <= 1'b1;
            state    <= ST_LOAD;
`ifdef STREAM_MODE_EN
            stream_on <= (cmd_kind == CMD_STREAM_ON);
            stop_req  <= 1'b0;
            pass_wrap <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          if (tx_ready) begin
            tx_en       <= 1'b1;
            tx_write_en <= 1'b1;
            csum        <= csum ^ tx_data;
            cnt         <= '0;
            state       <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          tx_en       <= 1'b0;
          tx_write_en <= 1'b0;
          cnt         <= '0;
          state       <= ST_WAIT_BUSY;
        end

        ST_WAIT_BUSY: begin
          if (!tx_ready) begin
            cnt   <= '0;
            state <= ST_WAIT_DONE;
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            tx_data <= 8'd0;
            cnt     <= '0;
            state   <= ST_IDLE;
`ifdef STREAM_MODE_EN
            stream_on <= 1'b0;
            stop_req  <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_DONE: begin
          if (tx_ready) begin
            cnt <= '0;
            if (byte_idx != LAST_BYTE_IDX) begin
              byte_idx <= byte_idx + 3'd1;
              tx_data  <= frame_byte(byte_idx + 3'd1, ch_idx, cur_sample, csum);
              state    <= ST_LOAD;
`ifdef STREAM_MODE_EN
            end else if (!stop_req && all_mode && (ch_idx != 2'd3)) begin
              pass_wrap <= 1'b0;
              state     <= ST_NEXT_CH;
            end else if (!stop_req && stream_on) begin
              pass_wrap <= 1'b1;
              state     <= ST_NEXT_CH;
            end else begin
              busy      <= 1'b0;
              tx_data   <= 8'd0;
              stream_on <= 1'b0;
              stop_req  <= 1'b0;
              state     <= ST_IDLE;
            end
`else
            end else if (all_mode && (ch_idx != 2'd3)) begin
              state <= ST_NEXT_CH;
            end else begin
              busy    <= 1'b0;
              tx_data <= 8'd0;
              state   <= ST_IDLE;
            end
`endif
          end else if (cnt == CNT_LAST) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            tx_data <= 8'd0;
            cnt     <= '0;
            state   <= ST_IDLE;
`ifdef STREAM_MODE_EN
            stream_on <= 1'b0;
            stop_req  <= 1'b0;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_NEXT_CH: begin
`ifdef STREAM_MODE_EN
          if (pass_wrap) begin
            ch_idx    <= 2'd0;
            snapshot  <= sample_bus;
            all_mode  <= 1'b1;
            pass_wrap <= 1'b0;
          end else begin
            ch_idx <= ch_idx + 2'd1;
          end
`else
          ch_idx <= ch_idx + 2'd1;
`endif
          byte_idx <= 3'd0;
          csum     <= 8'd0;
          cnt      <= '0;
          tx_data  <= SYNC_BYTE;
          state    <= ST_LOAD;
        end

        default: begin
          busy    <= 1'b0;
          tx_data <= 8'd0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_scheduler.sv
// Directed bench for uart_frame_scheduler with a simple UART TX model.
module tb_uart_frame_scheduler;

  localparam int SAMPLE_W   = 10;
  localparam int TX_TIMEOUT = 4096;

  logic                  clk = 1'b0;
  logic                  reset_b = 1'b0;
  logic [7:0]            rx_data = 8'd0;
  logic                  rx_ready = 1'b0;
  logic [4*SAMPLE_W-1:0] sample_bus = '0;
  logic                  tx_ready = 1'b1;
  logic [7:0]            tx_data;
  logic                  tx_en;
  logic                  tx_write_en;
  logic                  busy;
  logic                  cmd_err;
  logic                  cmd_drop;
  logic                  timeout;

  uart_frame_scheduler #(
    .SAMPLE_W   (SAMPLE_W),
    .SYNC_BYTE  (8'hA5),
    .TX_TIMEOUT (TX_TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset_b     (reset_b),
    .rx_data     (rx_data),
    .rx_ready    (rx_ready),
    .sample_bus  (sample_bus),
    .tx_ready    (tx_ready),
    .tx_data     (tx_data),
    .tx_en       (tx_en),
    .tx_write_en (tx_write_en),
    .busy        (busy),
    .cmd_err     (cmd_err),
    .cmd_drop    (cmd_drop),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  bit         model_stuck = 1'b0;
  logic [7:0] txq[$];
  int         run_len = 0;
  int         max_run = 0;
  int         we_mis  = 0;
  int         err_cnt = 0;
  int         drop_cnt = 0;
  int         to_cnt  = 0;

  localparam logic [4*SAMPLE_W-1:0] BUS1 = {10'h3C0, 10'h0AA, 10'h2F3, 10'h111};
  localparam logic [4*SAMPLE_W-1:0] BUS2 = {10'h155, 10'h200, 10'h3FF, 10'h001};

  logic [7:0] exp_ch2 [5]  = '{8'hA5, 8'h42, 8'h02, 8'hF3, 8'h16};
  logic [7:0] exp_ch1 [5]  = '{8'hA5, 8'h41, 8'h01, 8'h11, 8'hF4};
  logic [7:0] exp_all [20] = '{8'hA5, 8'h41, 8'h00, 8'h01, 8'hE5,
                               8'hA5, 8'h42, 8'h03, 8'hFF, 8'h1B,
                               8'hA5, 8'h43, 8'h02, 8'h00, 8'hE4,
                               8'hA5, 8'h44, 8'h01, 8'h55, 8'hB5};

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_cmd(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_ready = 1'b1;
    @(negedge clk);
    rx_ready = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_bytes(input int k);
    int n;
    n = 0;
    while (txq.size() < k && n < 500) begin
      @(negedge clk);
      n++;
    end
  endtask

  // UART TX model: goes busy one cycle after a strobe, idle again 3 cycles later
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (tx_en && !model_stuck) begin
        tx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 tx_ready = 1'b1;
      end
    end
  end

  // Monitor: capture strobed bytes and count pulse-cycles
  initial begin
    forever begin
      @(negedge clk);
      if (tx_en) begin
        txq.push_back(tx_data);
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (tx_en !== tx_write_en) we_mis++;
      if (cmd_err)  err_cnt++;
      if (cmd_drop) drop_cnt++;
      if (timeout)  to_cnt++;
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int err0, drop0, to0;
    logic busy_seen;

    // Reset state
    repeat (2) @(negedge clk);
    check_eq("reset_outputs", {20'd0, tx_data, tx_en, tx_write_en, busy, cmd_err, cmd_drop, timeout}, 32'd0);
    reset_b = 1'b1;
    repeat (3) @(negedge clk);

    // Single channel 2 frame with ready UART
    sample_bus = BUS1;
    txq.delete();
    max_run = 0;
    send_cmd(8'h32);
    check_eq("t1_busy_after_accept", {31'd0, busy}, 32'd1);
    check_eq("t1_no_strobe_in_load", {31'd0, tx_en}, 32'd0);
    @(negedge clk);
    check_eq("t1_first_strobe_latency", {31'd0, tx_en}, 32'd1);
    check_eq("t1_first_byte", {24'd0, tx_data}, 32'hA5);
    wait_idle("t1_done");
    check_eq("t1_count", txq.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < txq.size()) check_eq($sformatf("t1_byte%0d", i), {24'd0, txq[i]}, {24'd0, exp_ch2[i]});
    check_eq("t1_strobe_width", max_run, 32'd1);
    check_eq("t1_write_en_matches_en", we_mis, 32'd0);

    // All channels, sample bus changes mid-transfer
    sample_bus = BUS2;
    txq.delete();
    send_cmd(8'h30);
    wait_bytes(7);
    sample_bus = {4{10'h0F0}};
    wait_idle("t2_done");
    check_eq("t2_count", txq.size(), 32'd20);
    for (int i = 0; i < 20; i++)
      if (i < txq.size()) check_eq($sformatf("t2_byte%0d", i), {24'd0, txq[i]}, {24'd0, exp_all[i]});

    // Unknown command
    txq.delete();
    err0  = err_cnt;
    drop0 = drop_cnt;
    send_cmd(8'h7A);
    busy_seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
    end
    check_eq("t3_err_pulses", err_cnt - err0, 32'd1);
    check_eq("t3_no_drop", drop_cnt - drop0, 32'd0);
    check_eq("t3_no_tx", txq.size(), 32'd0);
    check_eq("t3_busy_low", {31'd0, busy_seen}, 32'd0);

    // Valid command while busy is dropped
    sample_bus = BUS2;
    txq.delete();
    err0  = err_cnt;
    drop0 = drop_cnt;
    send_cmd(8'h30);
    wait_bytes(8);
    send_cmd(8'h31);
    wait_idle("t4_done");
    check_eq("t4_drop_pulses", drop_cnt - drop0, 32'd1);
    check_eq("t4_no_err", err_cnt - err0, 32'd0);
    check_eq("t4_count", txq.size(), 32'd20);
    for (int i = 0; i < 20; i++)
      if (i < txq.size()) check_eq($sformatf("t4_byte%0d", i), {24'd0, txq[i]}, {24'd0, exp_all[i]});

    // UART never goes busy: handshake timeout
    model_stuck = 1'b1;
    sample_bus = BUS1;
    txq.delete();
    to0 = to_cnt;
    send_cmd(8'h33);
    n = 0;
    while (!tx_en && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_strobe", {31'd0, tx_en}, 32'd1);
    n = 0;
    while (!timeout && n < TX_TIMEOUT + 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("t5_timeout_pulse", {31'd0, timeout}, 32'd1);
    check_eq("t5_timeout_delay_window", {31'd0, (n >= TX_TIMEOUT) && (n <= TX_TIMEOUT + 2)}, 32'd1);
    check_eq("t5_busy_low_at_timeout", {31'd0, busy}, 32'd0);
    @(negedge clk);
    check_eq("t5_outputs_zero", {20'd0, tx_data, tx_en, tx_write_en, busy, cmd_err, cmd_drop, timeout}, 32'd0);
    check_eq("t5_single_pulse", to_cnt - to0, 32'd1);
    check_eq("t5_one_byte_only", txq.size(), 32'd1);
    model_stuck = 1'b0;
    repeat (4) @(negedge clk);

    // Asynchronous reset during WAIT_DONE of byte 3, then a fresh frame
    sample_bus = BUS1;
    txq.delete();
    send_cmd(8'h32);
    n = 0;
    while (!(tx_en && tx_data == 8'h02) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_eq("t6_reached_byte3", {24'd0, tx_data}, 32'h02);
    @(negedge clk);
    @(negedge clk);
    check_eq("t6_busy_before_reset", {31'd0, busy}, 32'd1);
    #1 reset_b = 1'b0;
    #1;
    check_eq("t6_async_reset_outputs", {21'd0, tx_data, tx_en, tx_write_en, busy}, 32'd0);
    repeat (3) @(negedge clk);
    reset_b = 1'b1;
    repeat (8) @(negedge clk);
    txq.delete();
    send_cmd(8'h31);
    wait_idle("t6_done");
    check_eq("t6_count", txq.size(), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < txq.size()) check_eq($sformatf("t6_byte%0d", i), {24'd0, txq[i]}, {24'd0, exp_ch1[i]});
    check_eq("t6_write_en_matches_en", we_mis, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
